// File: rtl/cpu_datapath_if.sv
// Control/status bundle between the sequencing controller and cpu_datapath.
// The controller (or a bench) drives controls through master; the datapath uses slave.
interface cpu_datapath_if;
    logic       sel;
    logic       rd;
    logic       wr;
    logic       data_e;
    logic       ld_ir;
    logic       ld_ac;
    logic       ld_pc;
    logic       inc_pc;
    logic       halt;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [2:0] op_out;
    logic       is_zero;
    logic [4:0] pc_out;
    logic [7:0] ac_out;
    logic       halted;

    modport master (
        output sel, rd, wr, data_e, ld_ir, ld_ac, ld_pc, inc_pc, halt,
        output prog_we, prog_addr, prog_data,
        input  op_out, is_zero, pc_out, ac_out, halted
    );

    modport slave (
        input  sel, rd, wr, data_e, ld_ir, ld_ac, ld_pc, inc_pc, halt,
        input  prog_we, prog_addr, prog_data,
        output op_out, is_zero, pc_out, ac_out, halted
    );
endinterface

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: 32x8 async-read memory, IR/AC/PC, sticky halt.
// Optional macro ALU_OVF_EN adds a sticky ADD carry-out flag on port ovf.
module cpu_datapath (
    input  logic          clk,
    input  logic          rst,
    cpu_datapath_if.slave bus
`ifdef ALU_OVF_EN
    ,
    output logic          ovf
`endif
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;

    logic [7:0] r_mem [0:31];
    logic [7:0] r_ir;
    logic [7:0] r_ac;
    logic [4:0] r_pc;
    logic       r_halted;

    logic [4:0] w_addr;
    logic [7:0] w_bus;
    logic [7:0] w_alu;
    logic       w_cpu_we;

    assign w_addr = bus.sel ? r_pc : r_ir[4:0];

    always_comb begin
        w_bus = 8'h00;
        if (bus.rd)
            w_bus = r_mem[w_addr];
        else if (bus.data_e)
            w_bus = r_ac;
    end

`ifdef ALU_OVF_EN
    logic [8:0] w_sum;
    assign w_sum = {1'b0, r_ac} + {1'b0, w_bus};
`else
    logic [7:0] w_sum;
    assign w_sum = r_ac + w_bus;
`endif

    always_comb begin
        w_alu = r_ac;
        case (r_ir[7:5])
            OP_ADD:  w_alu = w_sum[7:0];
            OP_AND:  w_alu = r_ac & w_bus;
            OP_XOR:  w_alu = r_ac ^ w_bus;
            OP_LDA:  w_alu = w_bus;
            default: w_alu = r_ac;
        endcase
    end

    // A CPU store needs the AC on the bus, so a concurrent memory read kills it.
    assign w_cpu_we = bus.wr & bus.data_e & ~bus.rd & ~r_halted & ~rst;

    // Memory is never reset; program loading works in every state.
    always_ff @(posedge clk) begin
        if (bus.prog_we)
            r_mem[bus.prog_addr] <= bus.prog_data;
        else if (w_cpu_we)
            r_mem[w_addr] <= r_ac;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir     <= 8'h00;
            r_ac     <= 8'h00;
            r_pc     <= 5'd0;
            r_halted <= 1'b0;
        end else begin
            if (bus.halt)
                r_halted <= 1'b1;
            if (!r_halted) begin
                if (bus.ld_ir)
                    r_ir <= w_bus;
                if (bus.ld_ac)
                    r_ac <= w_alu;
                if (bus.ld_pc)
                    r_pc <= r_ir[4:0];
                else if (bus.inc_pc)
                    r_pc <= r_pc + 5'd1;
            end
        end
    end

`ifdef ALU_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (!r_halted && bus.ld_ac && r_ir[7:5] == OP_ADD && w_sum[8])
            r_ovf <= 1'b1;
    end
    assign ovf = r_ovf;
`endif

    assign bus.op_out  = r_ir[7:5];
    assign bus.is_zero = (r_ac == 8'h00);
    assign bus.pc_out  = r_pc;
    assign bus.ac_out  = r_ac;
    assign bus.halted  = r_halted;

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 sel  input  1  address select: 1 = PC, 0 = IR operand field.
REQ-005 rd  input  1  memory read enable; drives the internal data bus from memory.
REQ-006 wr  input  1  memory write strobe.
REQ-007 data_e  input  1  accumulator drive enable onto the internal data bus.
REQ-008 ld_ir  input  1  load IR from the data bus.
REQ-009 ld_ac  input  1  load AC from the ALU result.
REQ-010 ld_pc  input  1  load PC from IR[4:0].
REQ-011 inc_pc  input  1  increment PC.
REQ-012 halt  input  1  stop request; sets the sticky halted state.
REQ-013 prog_we  input  1  program-load write strobe.
REQ-014 prog_addr  input  5  program-load address.
REQ-015 prog_data  input  8  program-load data.
REQ-016 op_out  output  3  opcode, equal to IR[7:5]; returned to the controller as op_in.
REQ-017 is_zero  output  1  high when AC == 8'h00 (combinational).
REQ-018 pc_out  output  5  current PC.
REQ-019 ac_out  output  8  current AC.
REQ-020 halted  output  1  sticky halt status.

Function
REQ-021 Storage SHALL be: 32x8 memory, IR 8b, AC 8b, PC 5b, halted 1b; the instruction word is opcode [7:5] and operand address [4:0].
REQ-022 Address SHALL be sel ? PC : IR[4:0], combinational.
REQ-023 Data bus SHALL be: mem[addr] when rd=1; else AC when data_e=1; else 8'h00.
REQ-024 Memory read SHALL be asynchronous, giving zero-latency visibility to the IR and the ALU in the same cycle.
REQ-025 Memory write: mem[addr] <= AC at the clock edge when wr=1, data_e=1 and rd=0.
REQ-026 When wr=1 and rd=1 together, the write SHALL be suppressed.
REQ-027 When wr=1 and data_e=0, no write SHALL occur.
REQ-028 ld_ir=1: IR <= data bus at the clock edge.
REQ-029 ld_ac=1: AC <= ALU result, selected by IR[7:5]:
- 010 ADD: AC+bus, mod 256, carry discarded.
- 011 AND: AC&bus.
- 100 XOR: AC^bus.
- 101 LDA: bus.
- all other opcodes: AC unchanged.
REQ-030 PC update priority SHALL be:
- ld_pc: PC <= IR[4:0].
- else inc_pc: PC <= PC+1, wrapping from 31 to 0.
- else: PC held.
REQ-031 halt=1 at a clock edge SHALL set halted=1 from the next cycle onward.
REQ-032 While halted=1, IR, AC, PC and CPU-side memory writes SHALL be frozen; only rst clears halted.
REQ-033 prog_we=1: mem[prog_addr] <= prog_data at the clock edge, in any state including halted and rst.
REQ-034 prog_we SHALL take priority over a CPU write in the same cycle.
REQ-035 All control inputs arriving in the same cycle SHALL act in parallel, each using pre-edge register values (e.g. ld_ir with ld_ac decodes the old IR).

Reset
REQ-036 On rst=1 at a clock edge: IR=0, AC=0, PC=0, halted=0; from the next cycle op_out=3'b000, is_zero=1, pc_out=0, ac_out=0.
REQ-037 rst SHALL override every control input, including halt and ld_*, in the same cycle; reset mid-instruction aborts it without writing memory.
REQ-038 Memory contents SHALL NOT be cleared by rst.

Configuration
REQ-039 Macro ALU_OVF_EN: when defined, add output port ovf (1b), a sticky register holding the carry-out of any ADD executed with ld_ac=1; cleared only by rst.
REQ-040 Without ALU_OVF_EN: the ovf port and register SHALL be absent, and ADD carry is silently discarded.

Verification
REQ-041 Reset: rst=1 for 1 cycle -> PC=0, AC=0, op_out=000, is_zero=1, halted=0.
REQ-042 Fetch: prog mem[0]=8'hA5; sel=1, rd=1, ld_ir=1, then inc_pc=1 -> op_out=3'b101, IR[4:0]=5, PC=1.
REQ-043 LDA/ADD: mem[5]=8'hF0, mem[6]=8'h20; LDA 5 then ADD 6 -> AC=8'h10, is_zero=0, ovf=1 if ALU_OVF_EN is defined.
REQ-044 STO: AC=8'h3C, IR=8'hC9, sel=0, data_e=1, wr=1 -> mem[9]=8'h3C; repeating with rd=1 leaves mem[9] unchanged.
REQ-045 PC: PC=31 with inc_pc=1 -> PC=0; ld_pc=1 and inc_pc=1 with IR[4:0]=12 -> PC=12.
REQ-046 Halt: pulse halt, then drive inc_pc and ld_ac for 5 cycles -> PC/AC unchanged and halted=1; rst -> halted=0.
